// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO read-side word packer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: packer FSM state encoding, default geometry and flush timeout.
package fifo_ctrl_pkg;

   // FILL: issuing reads and capturing bytes; OUT: word presented, waiting for the consumer.
   typedef enum logic {
      FILL = 1'b0,
      OUT  = 1'b1
   } state_t;

   localparam int DEF_BYTE_WIDTH     = 8;
   localparam int DEF_BYTES_PER_WORD = 4;
   localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/fifo_word_packer.sv
// Reads BYTES_PER_WORD bytes from a byte FIFO and packs them little-endian into one word.
// Latency: BYTES_PER_WORD+1 cycles from first read to word_valid with back-to-back reads.
// Backpressure: holds the word and stops reading while word_ready=0; one word in flight.
//
// Ports:
//   clk, reset (async, active low), clear (sync abort of the partial/held word)
//   fifo_empty / fifo_read / fifo_read_data : FIFO read port, data returns one cycle after the read
//   word_valid / word_ready / word_data     : packed-word handshake, byte 0 in the LSBs
//   word_bytes (only with FIFO_WORD_PACKER_TIMEOUT_EN) : bytes in the presented word
//
// Optional feature macro FIFO_WORD_PACKER_TIMEOUT_EN: flush a partial word after
// TIMEOUT_CYCLES idle cycles and report its length on word_bytes.
module fifo_word_packer
   import fifo_ctrl_pkg::*;
#(
   parameter int BYTE_WIDTH     = DEF_BYTE_WIDTH,
   parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 clear,
   input  logic                                 fifo_empty,
   output logic                                 fifo_read,
   input  logic [BYTE_WIDTH-1:0]                fifo_read_data,
   output logic                                 word_valid,
   input  logic                                 word_ready,
`ifdef FIFO_WORD_PACKER_TIMEOUT_EN
   output logic [$clog2(BYTES_PER_WORD+1)-1:0]  word_bytes,
`endif
   output logic [BYTE_WIDTH*BYTES_PER_WORD-1:0] word_data
);

   localparam int             CW   = $clog2(BYTES_PER_WORD + 1);
   localparam int             WW   = BYTE_WIDTH * BYTES_PER_WORD;
   localparam logic [CW-1:0]  LAST = CW'(BYTES_PER_WORD - 1);
   localparam logic [CW-1:0]  FULL = CW'(BYTES_PER_WORD);

   if (BYTES_PER_WORD < 2 || BYTES_PER_WORD > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("fifo_word_packer: BYTES_PER_WORD must be 2..8 and TIMEOUT_CYCLES >= 1");
   end

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_issued;
   logic [CW-1:0]   r_captured;
   logic            r_rd_pend;
   logic [WW-1:0]   r_word_data;
   logic            w_capture;
   logic            w_last;
   logic            w_handshake;
   logic            w_timeout;

`ifdef FIFO_WORD_PACKER_TIMEOUT_EN
   localparam int            IW      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IW-1:0] IDLE_TO = IW'(TIMEOUT_CYCLES);

   logic [IW-1:0]   r_idle;

   // Flush only with no read outstanding, so the partial word is exactly what was captured.
   assign w_timeout = (r_state == FILL) && (r_captured != '0) && (r_idle == IDLE_TO) && !r_rd_pend;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_idle <= '0;
      end else if (clear || (r_state != FILL) || (r_captured == '0) || w_capture) begin
         r_idle <= '0;
      end else if (r_idle != IDLE_TO) begin
         r_idle <= r_idle + IW'(1);
      end
   end

   assign word_bytes = (r_state == OUT) ? r_captured : '0;
`else
   assign w_timeout = 1'b0;
`endif

   // Reads are gated by reset as well so nothing is popped while the block is held in reset.
   // The timeout term stops a read racing the flush into OUT.
   assign fifo_read   = reset && (r_state == FILL) && !fifo_empty && (r_issued < FULL)
                        && !clear && !w_timeout;
   // A byte returning during clear belongs to the aborted word and is dropped.
   assign w_capture   = r_rd_pend && !clear;
   assign w_last      = w_capture && (r_captured == LAST);
   assign w_handshake = (r_state == OUT) && word_ready;

   always_comb begin
      w_state_nxt = r_state;
      if (clear) begin
         w_state_nxt = FILL;
      end else begin
         case (r_state)
            FILL:    if (w_last || w_timeout) w_state_nxt = OUT;
            OUT:     if (word_ready)          w_state_nxt = FILL;
            default: w_state_nxt = FILL;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= FILL;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_issued    <= '0;
         r_captured  <= '0;
         r_rd_pend   <= 1'b0;
         r_word_data <= '0;
      end else if (clear || w_handshake) begin
         r_issued    <= '0;
         r_captured  <= '0;
         r_rd_pend   <= 1'b0;
         r_word_data <= '0;
      end else begin
         r_rd_pend <= fifo_read;
         if (fifo_read) begin
            r_issued <= r_issued + CW'(1);
         end
         if (w_capture) begin
            for (int i = 0; i < BYTES_PER_WORD; i++) begin
               if (r_captured == CW'(i)) begin
                  r_word_data[i*BYTE_WIDTH +: BYTE_WIDTH] <= fifo_read_data;
               end
            end
            r_captured <= r_captured + CW'(1);
         end
      end
   end

   assign word_valid = (r_state == OUT);
   assign word_data  = r_word_data;

endmodule

// File: tb/tb_fifo_word_packer.sv
module tb_fifo_word_packer;

`ifdef FIFO_WORD_PACKER_TIMEOUT_EN
   localparam int TO    = 16;
   localparam int WAIT3 = 10;
`else
   localparam int TO    = 1024;
   localparam int WAIT3 = 20;
`endif

   logic        clk        = 1'b0;
   logic        reset      = 1'b0;
   logic        clear      = 1'b0;
   logic        word_ready = 1'b1;
   logic        fifo_empty;
   logic        fifo_read;
   logic [7:0]  fifo_read_data = 8'h00;
   logic        word_valid;
   logic [31:0] word_data;
`ifdef FIFO_WORD_PACKER_TIMEOUT_EN
   logic [2:0]  word_bytes;
`endif

   int total = 0;
   int bad   = 0;

   // Byte FIFO in front of the packer; shares the packer's reset.
   logic [7:0] mem [0:255];
   logic [7:0] wr_ptr = 8'd0;
   logic [7:0] rd_ptr = 8'd0;
   int         rd_cnt = 0;

   always #5 clk = ~clk;

   assign fifo_empty = (wr_ptr == rd_ptr);

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= wr_ptr;
      end else if (fifo_read) begin
         fifo_read_data <= mem[rd_ptr];
         rd_ptr         <= rd_ptr + 8'd1;
      end
   end

   always @(posedge clk) begin
      if (fifo_read) rd_cnt <= rd_cnt + 1;
   end

   fifo_word_packer #(
      .BYTE_WIDTH     (8),
      .BYTES_PER_WORD (4),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .clear          (clear),
      .fifo_empty     (fifo_empty),
      .fifo_read      (fifo_read),
      .fifo_read_data (fifo_read_data),
      .word_valid     (word_valid),
      .word_ready     (word_ready),
`ifdef FIFO_WORD_PACKER_TIMEOUT_EN
      .word_bytes     (word_bytes),
`endif
      .word_data      (word_data)
   );

   // The FIFO must never be read while it reports empty.
   always @(negedge clk) begin
      if (reset) begin
         total++;
         assert (!(fifo_read && fifo_empty)) else begin
            bad++;
            $error("FAIL overread: observed fifo_read=%0b with fifo_empty=%0b, expected no read", fifo_read, fifo_empty);
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      mem[wr_ptr] = b;
      wr_ptr      = wr_ptr + 8'd1;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_word(input string tag, input int budget, output int cyc);
      cyc = 0;
      while (!word_valid && cyc < budget) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check({tag, "_arrive"}, {63'd0, word_valid}, 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cyc;
      int r0;

      // Reset state, including a byte arriving while reset is held.
      step(3);
      check("rst_valid", {63'd0, word_valid}, 64'd0);
      check("rst_data",  {32'd0, word_data},  64'd0);
      push(8'hEE);
      #1;
      check("rst_read_gated", {63'd0, fifo_read}, 64'd0);
      step(1);
      reset = 1'b1;
      step(2);
      check("rst_fifo_flushed", {63'd0, fifo_empty}, 64'd1);

      // Single word, consumer always ready.
      r0 = rd_cnt;
      push(8'h70); push(8'h71); push(8'h72); push(8'h73);
      wait_word("t1", 20, cyc);
      check("t1_latency", 64'(cyc), 64'd5);
      check("t1_data", {32'd0, word_data}, 64'h73727170);
`ifdef FIFO_WORD_PACKER_TIMEOUT_EN
      check("t1_bytes", {61'd0, word_bytes}, 64'd4);
`endif
      step(1);
      check("t1_valid_drop", {63'd0, word_valid}, 64'd0);
      check("t1_data_clr",   {32'd0, word_data},  64'd0);
      check("t1_reads",      64'(rd_cnt - r0),    64'd4);
      check("t1_empty",      {63'd0, fifo_empty}, 64'd1);

      // Consumer stall with a second word queued behind it.
      word_ready = 1'b0;
      r0 = rd_cnt;
      for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
      wait_word("t2a", 20, cyc);
      check("t2_w0", {32'd0, word_data}, 64'h13121110);
      for (int i = 0; i < 10; i++) begin
         step(1);
         check("t2_stall", {30'd0, word_valid, fifo_read, word_data}, {30'd0, 1'b1, 1'b0, 32'h13121110});
      end
      check("t2_stall_reads", 64'(rd_cnt - r0), 64'd4);
      word_ready = 1'b1;
      step(1);
      check("t2_after_hs", {63'd0, word_valid}, 64'd0);
      wait_word("t2b", 20, cyc);
      check("t2_w1", {32'd0, word_data}, 64'h17161514);
      step(1);
      check("t2_empty", {63'd0, fifo_empty}, 64'd1);

      // FIFO runs dry mid-word.
      push(8'hAA); push(8'hBB);
      step(WAIT3);
      check("t3_partial", {63'd0, word_valid}, 64'd0);
      push(8'hCC); push(8'hDD);
      wait_word("t3", 20, cyc);
      check("t3_data", {32'd0, word_data}, 64'hDDCCBBAA);
      step(1);

      // Clear drops captured bytes.
      push(8'h01); push(8'h02);
      step(5);
      clear = 1'b1;
      step(1);
      clear = 1'b0;
      check("t4_clr_data",  {32'd0, word_data},  64'd0);
      check("t4_clr_valid", {63'd0, word_valid}, 64'd0);
      push(8'h03); push(8'h04); push(8'h05); push(8'h06);
      wait_word("t4a", 20, cyc);
      check("t4_data", {32'd0, word_data}, 64'h06050403);
      step(1);

      // Clear while a read is in flight: the returning byte is discarded.
      push(8'h99);
      step(1);
      clear = 1'b1;
      step(1);
      clear = 1'b0;
      check("t4_inflight_data", {32'd0, word_data}, 64'd0);
      push(8'h08); push(8'h09); push(8'h0A); push(8'h0B);
      wait_word("t4b", 20, cyc);
      check("t4_inflight_word", {32'd0, word_data}, 64'h0B0A0908);
      step(1);

      // Asynchronous reset just before the third capture.
      push(8'h30); push(8'h31); push(8'h32); push(8'h33);
      step(3);
      reset = 1'b0;
      #1;
      check("t5_rst_valid", {63'd0, word_valid}, 64'd0);
      check("t5_rst_data",  {32'd0, word_data},  64'd0);
      check("t5_rst_read",  {63'd0, fifo_read},  64'd0);
      step(2);
      reset = 1'b1;
      step(1);
      push(8'h40); push(8'h41); push(8'h42); push(8'h43);
      wait_word("t5", 20, cyc);
      check("t5_data", {32'd0, word_data}, 64'h43424140);
      step(1);

`ifdef FIFO_WORD_PACKER_TIMEOUT_EN
      // Partial word flushed after the idle timeout.
      check("t6_bytes_idle", {61'd0, word_bytes}, 64'd0);
      push(8'h55);
      wait_word("t6", 40, cyc);
      check("t6_data",  {32'd0, word_data},  64'h00000055);
      check("t6_bytes", {61'd0, word_bytes}, 64'd1);
      step(1);
      check("t6_valid_drop", {63'd0, word_valid}, 64'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
